cpu_bus_slave: RTL



---
 rtl/cpu_bus_slave_if.sv | 34 +++
 rtl/cpu_bus_slave.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_slave_if.sv
// cpu_bus_slave_if
// Byte-wide CPU bus between a CPU read/write master and cpu_bus_slave.
//   ce      : chip enable (master -> slave)
//   rd      : read strobe (master -> slave)
//   wr      : write strobe (master -> slave)
//   addr    : byte address (master -> slave)
//   data_wr : write data (master -> slave)
//   data_rd : read data, combinational (slave -> master)
interface cpu_bus_slave_if;
  logic       ce;
  logic       rd;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] data_wr;
  logic [7:0] data_rd;

  modport master (
    output ce,
    output rd,
    output wr,
    output addr,
    output data_wr,
    input  data_rd
  );

  modport slave (
    input  ce,
    input  rd,
    input  wr,
    input  addr,
    input  data_wr,
    output data_rd
  );
endinterface

// File: rtl/cpu_bus_slave.sv
// cpu_bus_slave
// Byte-wide CPU bus target: control register, status with sticky error
// flags, a byte FIFO, a count register and 16 scratch registers.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-low reset
//   bus       : cpu_bus_slave_if.slave (ce, rd, wr, addr, data_wr, data_rd)
//   enable    : CTRL[0], downstream decoder enable
//   binary_in : CTRL[7:4], downstream decoder select
//   irq       : registered CTRL[1] & FIFO not empty
// Address map:
//   0x00 CTRL   R/W  bit0 enable, bit1 irq_en, bits7:4 binary_in
//   0x01 STATUS      bit0 empty, bit1 full, bit2 overflow (W1C), bit3 underflow (W1C)
//   0x02 FIFO        write pushes, read pops
//   0x03 COUNT  RO
//   0x10-0x1F   scratch R/W
module cpu_bus_slave #(
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_bus_slave_if.slave        bus,
  output logic                  enable,
  output logic [3:0]            binary_in,
  output logic                  irq
);

  localparam int PW = CW - 1;

  logic       w_wrAcc;
  logic       w_rdAcc;
  logic       w_wrEdge;
  logic       w_rdEdge;
  logic       w_empty;
  logic       w_full;
  logic       w_ctrlWr;
  logic       w_stsWr;
  logic       w_push;
  logic       w_pop;
  logic       w_scrWr;
  logic [7:0] w_status;
  logic [7:0] w_fifoRd;
  logic [7:0] w_rdData;

  logic          r_wrAccD;
  logic          r_rdAccD;
  logic [7:0]    r_ctrl;
  logic          r_overflow;
  logic          r_underflow;
  logic          r_irq;
  logic [7:0]    r_scratch [16];
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wPtr;
  logic [PW-1:0] r_rPtr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_popData;

  // A simultaneous rd and wr counts only as a write.
  assign w_wrAcc  = bus.ce & bus.wr;
  assign w_rdAcc  = bus.ce & bus.rd & ~bus.wr;
  // Side effects fire only on the first cycle of a held access.
  assign w_wrEdge = w_wrAcc & ~r_wrAccD;
  assign w_rdEdge = w_rdAcc & ~r_rdAccD;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));

  assign w_ctrlWr = w_wrEdge & (bus.addr == 8'h00);
  assign w_stsWr  = w_wrEdge & (bus.addr == 8'h01);
  assign w_push   = w_wrEdge & (bus.addr == 8'h02);
  assign w_pop    = w_rdEdge & (bus.addr == 8'h02);
  assign w_scrWr  = w_wrEdge & (bus.addr[7:4] == 4'h1);

  assign w_status = {4'b0000, r_underflow, r_overflow, w_full, w_empty};

  // Before the pop edge the head is shown directly; once the pop has
  // happened and the read is still held, the consumed byte is shown so the
  // data stays stable for the whole access.
  assign w_fifoRd = r_rdAccD ? r_popData : (w_empty ? 8'h00 : r_mem[r_rPtr]);

  assign enable    = r_ctrl[0];
  assign binary_in = r_ctrl[7:4];
  assign irq       = r_irq;
  assign bus.data_rd = w_rdData;

  // Read data mux; anything outside the map, or no read access, gives zero.
  always_comb begin
    w_rdData = 8'h00;
    if (w_rdAcc) begin
      case (bus.addr)
        8'h00:   w_rdData = r_ctrl;
        8'h01:   w_rdData = w_status;
        8'h02:   w_rdData = w_fifoRd;
        8'h03:   w_rdData = 8'(r_count);
        default: begin
          if (bus.addr[7:4] == 4'h1) begin
            w_rdData = r_scratch[bus.addr[3:0]];
          end
        end
      endcase
    end
  end

  // Control, status, scratch, FIFO pointers and edge-detect state. Sticky
  // flags let a new error event win over a same-edge write-one-to-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrAccD    <= 1'b0;
      r_rdAccD    <= 1'b0;
      r_ctrl      <= 8'h00;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_irq       <= 1'b0;
      r_wPtr      <= '0;
      r_rPtr      <= '0;
      r_count     <= '0;
      r_popData   <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        r_scratch[i] <= 8'h00;
      end
    end else begin
      r_wrAccD <= w_wrAcc;
      r_rdAccD <= w_rdAcc;
      r_irq    <= r_ctrl[1] & ~w_empty;

      if (w_ctrlWr) begin
        r_ctrl <= bus.data_wr & 8'hF3;
      end

      if (w_scrWr) begin
        r_scratch[bus.addr[3:0]] <= bus.data_wr;
      end

      r_overflow  <= (r_overflow  & ~(w_stsWr & bus.data_wr[2])) | (w_push & w_full);
      r_underflow <= (r_underflow & ~(w_stsWr & bus.data_wr[3])) | (w_pop & w_empty);

      if (w_push && !w_full) begin
        r_wPtr  <= r_wPtr + PW'(1);
        r_count <= r_count + CW'(1);
      end

      if (w_pop) begin
        if (w_empty) begin
          r_popData <= 8'h00;
        end else begin
          r_popData <= r_mem[r_rPtr];
          r_rPtr    <= r_rPtr + PW'(1);
          r_count   <= r_count - CW'(1);
        end
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && w_push && !w_full) begin
      r_mem[r_wPtr] <= bus.data_wr;
    end
  end

endmodule
